tick_watchdog: RTL and testbench



---
 rtl/tick_watchdog_pkg.sv | 20 ++
 rtl/tick_gap_counter.sv | 31 +++
 rtl/tick_watchdog.sv | 126 ++++++++++++
 tb/tb_tick_watchdog.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_watchdog_pkg.sv
// Shared types and defaults for the tick watchdog.
// Optional feature macro: TICK_WATCHDOG_RESYNC_EN.
package tick_watchdog_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_EARLY   = 2'b01,
      ERR_TIMEOUT = 2'b10
   } err_t;

   localparam int DEF_MIN_GAP = 99990;
   localparam int DEF_MAX_GAP = 100010;

endpackage

// File: rtl/tick_gap_counter.sv
// Cycle counter measuring the distance since the last tick.
// Stops at MAX_GAP-1 so it can never wrap.
module tick_gap_counter
   import tick_watchdog_pkg::*;
#(
   parameter int MAX_GAP = DEF_MAX_GAP,
   parameter int CBITS   = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CBITS-1:0] cnt,
   output logic             at_limit
);

   localparam logic [CBITS-1:0] LIMIT = CBITS'(MAX_GAP - 1);

   assign at_limit = (cnt == LIMIT);

   // Clear has priority; otherwise count up to the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !at_limit)
         cnt <= cnt + CBITS'(1);
   end

endmodule

// File: rtl/tick_watchdog.sv
// Watchdog for a periodic one-cycle tick: flags early and late ticks.
// Define TICK_WATCHDOG_RESYNC_EN to let a tick leave FAULT automatically.
module tick_watchdog
   import tick_watchdog_pkg::*;
#(
   parameter int MIN_GAP = DEF_MIN_GAP,
   parameter int MAX_GAP = DEF_MAX_GAP,
   parameter int CBITS   = 17,
   parameter int TBITS   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             clr,
   output logic             alive,
   output logic             fault,
   output logic [1:0]       err_code,
   output logic [CBITS-1:0] last_gap,
   output logic [TBITS-1:0] tick_count
);

   localparam logic [CBITS-1:0] MIN_G = CBITS'(MIN_GAP);

   state_t           state;
   err_t             err;
   logic [CBITS-1:0] cnt;
   logic [CBITS-1:0] gap;
   logic             at_limit;
   logic             cnt_clear;
   logic             cnt_en;

   assign gap      = cnt + CBITS'(1);
   assign alive    = (state == RUN);
   assign fault    = (state == FAULT);
   assign err_code = err;

   tick_gap_counter #(
      .MAX_GAP (MAX_GAP),
      .CBITS   (CBITS)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .enable   (cnt_en),
      .cnt      (cnt),
      .at_limit (at_limit)
   );

   // Counter control: zero in IDLE, restart on ticks, hold in FAULT.
   always_comb begin
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      unique case (state)
         IDLE: cnt_clear = 1'b1;
         RUN: begin
            if (clr || tick)
               cnt_clear = 1'b1;
            else
               cnt_en = 1'b1;
         end
         FAULT: begin
            cnt_clear = clr;
`ifdef TICK_WATCHDOG_RESYNC_EN
            if (tick)
               cnt_clear = 1'b1;
`endif
         end
         default: cnt_clear = 1'b1;
      endcase
   end

   // Main FSM with registered status; clr beats tick everywhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         err        <= ERR_NONE;
         last_gap   <= '0;
         tick_count <= '0;
      end else if (clr) begin
         state <= IDLE;
         err   <= ERR_NONE;
      end else begin
         unique case (state)
            IDLE: begin
               if (tick)
                  state <= RUN;
            end
            RUN: begin
               if (tick) begin
                  last_gap <= gap;
                  if (gap < MIN_G) begin
                     state <= FAULT;
                     err   <= ERR_EARLY;
                  end else if (tick_count != '1) begin
                     tick_count <= tick_count + TBITS'(1);
                  end
               end else if (at_limit) begin
                  state <= FAULT;
                  err   <= ERR_TIMEOUT;
               end
            end
            FAULT: begin
`ifdef TICK_WATCHDOG_RESYNC_EN
               if (tick) begin
                  state <= RUN;
                  err   <= ERR_NONE;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_excl: assert property (@(posedge clk) disable iff (rst)
      !(alive && fault));
   a_code: assert property (@(posedge clk) disable iff (rst)
      err_code != 2'b11);
   a_cause: assert property (@(posedge clk) disable iff (rst)
      fault |-> err_code != 2'b00);
`ifdef FORMAL
   a_live: assert property (@(posedge clk)
      s_eventually (rst || clr || alive || fault));
`endif

endmodule

// File: tb/tb_tick_watchdog.sv
// Scoreboard bench for tick_watchdog with a timestamp-based model.
// Honours TICK_WATCHDOG_RESYNC_EN in the reference model.
module tb_tick_watchdog;

   localparam int MINg = 4;
   localparam int MAXg = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        clr = 1'b0;
   logic        alive;
   logic        fault;
   logic [1:0]  err_code;
   logic [3:0]  last_gap;
   logic [15:0] tick_count;

   typedef struct {
      int alive;
      int fault;
      int err;
      int lg;
      int tc;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   // model: mode 0 idle, 1 run, 2 fault; gap from timestamps
   int m_mode = 0;
   int m_err = 0;
   int m_lg = 0;
   int m_tc = 0;
   int cyc = 0;
   int last = 0;

   tick_watchdog #(
      .MIN_GAP (MINg),
      .MAX_GAP (MAXg),
      .CBITS   (4),
      .TBITS   (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .clr        (clr),
      .alive      (alive),
      .fault      (fault),
      .err_code   (err_code),
      .last_gap   (last_gap),
      .tick_count (tick_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_err  = 0;
      m_lg   = 0;
      m_tc   = 0;
   endtask

   task automatic model(input logic t, input logic c);
      int g;
      cyc++;
      g = cyc - last;
      if (c) begin
         m_mode = 0;
         m_err  = 0;
      end else if (m_mode == 0) begin
         if (t) begin
            m_mode = 1;
            last   = cyc;
         end
      end else if (m_mode == 1) begin
         if (t) begin
            m_lg = g;
            if (g < MINg) begin
               m_mode = 2;
               m_err  = 1;
            end else begin
               if (m_tc < 65535) m_tc++;
               last = cyc;
            end
         end else if (g == MAXg) begin
            m_mode = 2;
            m_err  = 2;
         end
      end else begin
`ifdef TICK_WATCHDOG_RESYNC_EN
         if (t) begin
            m_mode = 1;
            m_err  = 0;
            last   = cyc;
         end
`endif
      end
   endtask

   task automatic step(input logic t, input logic c);
      exp_t e;
      @(negedge clk);
      tick = t;
      clr  = c;
      model(t, c);
      e.alive = (m_mode == 1);
      e.fault = (m_mode == 2);
      e.err   = m_err;
      e.lg    = m_lg;
      e.tc    = m_tc;
      q.push_back(e);
   endtask

   task automatic gap_tick(input int g);
      repeat (g - 1) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("drain", q.size(), 0);
   endtask

   // Monitor: outputs are valid every cycle after the driving edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("alive", int'(alive), e.alive);
            chk("fault", int'(fault), e.fault);
            chk("err_code", int'(err_code), e.err);
            chk("last_gap", int'(last_gap), e.lg);
            chk("tick_count", int'(tick_count), e.tc);
         end
      end
   end

   initial begin
      #12;
      chk("rst_alive", int'(alive), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_err", int'(err_code), 0);
      chk("rst_lg", int'(last_gap), 0);
      chk("rst_tc", int'(tick_count), 0);
      @(negedge clk);
      rst = 1'b0;

      // regular ticks every 6 cycles
      step(1'b1, 1'b0);
      repeat (4) gap_tick(6);
      step(1'b0, 1'b1);

      // boundary gaps
      step(1'b1, 1'b0);
      gap_tick(4);
      gap_tick(8);
      step(1'b0, 1'b1);

      // early tick
      step(1'b1, 1'b0);
      gap_tick(3);
      step(1'b0, 1'b0);

      // clr with tick in FAULT, then restart
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);

      // timeout, then a late tick
      gap_tick(9);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);

      // async reset mid-RUN with cnt=5
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      drain();
      rst = 1'b1;
      #1;
      chk("arst_alive", int'(alive), 0);
      chk("arst_fault", int'(fault), 0);
      chk("arst_err", int'(err_code), 0);
      chk("arst_lg", int'(last_gap), 0);
      chk("arst_tc", int'(tick_count), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0);
      gap_tick(4);

      // fault then tick (resync when enabled)
      gap_tick(2);
      gap_tick(5);
      gap_tick(6);
      step(1'b0, 1'b1);

      // random gaps and clears
      for (int i = 0; i < 80; i++) begin
         int g;
         logic c;
         g = $urandom_range(2, 10);
         c = ($urandom_range(0, 15) == 0);
         repeat (g - 1) step(1'b0, 1'b0);
         step(1'b1, c);
      end

      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
